// File: rtl/imem_pkg.sv
// imem_pkg: shared loader state encoding and word geometry.
//   Holds the state enum and the bytes-per-word constant and helper,
//   used by imem_loader and imem_word_asm.
package imem_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHK, DONE} state_t;
  localparam int DEF_DWIDTH = 16;
  localparam int BYTES_PER_WORD = DEF_DWIDTH / 8;
  function automatic int bytes_per_word(input int dwidth);
    return dwidth / 8;
  endfunction
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream sink and imem write port of the loader.
//   rx_data/rx_valid/rx_ready : byte stream, transfer on rx_valid && rx_ready
//   mem_data/mem_addr/mem_we  : imem write port
//   modport master is the loader side, modport slave the environment side.
interface imem_loader_if #(
  parameter int DWIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic [DWIDTH-1:0] mem_data;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic mem_we;
  modport master(input rx_data, rx_valid, output rx_ready, mem_data, mem_addr, mem_we);
  modport slave(output rx_data, rx_valid, input rx_ready, mem_data, mem_addr, mem_we);
endinterface

// File: rtl/imem_word_asm.sv
// imem_word_asm: byte shift register and byte counter assembling one word.
//   clk, rst : clock, synchronous active-high reset
//   shift    : accept byte_in this cycle
//   byte_in  : incoming byte, first byte of a word ends up least significant
//   nxt      : word value including byte_in (valid to capture on the last byte)
//   last     : byte_in is the final byte of the current word
module imem_word_asm import imem_pkg::*; #(
  parameter int DWIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic shift,
  input  logic [7:0] byte_in,
  output logic [DWIDTH-1:0] nxt,
  output logic last
);
  localparam int BPW = bytes_per_word(DWIDTH);
  localparam int CW = BPW > 1 ? $clog2(BPW) : 1;
  logic [DWIDTH-1:0] sr;
  logic [CW-1:0] cnt;
  // New bytes enter at the top and move down, so the first byte lands in the LSBs.
  assign nxt = DWIDTH'({byte_in, sr} >> 8);
  assign last = cnt == CW'(BPW - 1);
  always_ff @(posedge clk)
    if (rst) begin
      sr <= '0;
      cnt <= '0;
    end else if (shift) begin
      sr <= nxt;
      cnt <= last ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads num_words words from a byte stream into imem at base_addr.
//   clk, rst             : clock, synchronous active-high reset
//   start                : one-cycle load request, sampled only in IDLE
//   base_addr, num_words : load parameters, sampled with start
//   bus (master)         : byte stream in, imem write port out
//   busy, done, err      : not-idle flag, completion pulse, sticky checksum error
// Define IMEM_LOADER_CHECKSUM_EN to consume a trailing XOR checksum byte per load.
module imem_loader import imem_pkg::*; #(
  parameter int DWIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] num_words,
  imem_loader_if.master bus,
  output logic busy,
  output logic done,
  output logic err
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t FIN = CHK;
`else
  localparam state_t FIN = DONE;
`endif
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] word_idx, base, num, addr_q;
  logic [DWIDTH-1:0] data_q, nxt;
  logic fire, last, go;
  assign fire = bus.rx_valid && bus.rx_ready;
  assign go = state == IDLE && start;
  imem_word_asm #(.DWIDTH(DWIDTH)) u_asm (
    .clk(clk),
    .rst(rst),
    .shift(state == LOAD && fire),
    .byte_in(bus.rx_data),
    .nxt(nxt),
    .last(last)
  );
  always_comb begin
    state_n = state == IDLE  ? (start ? (num_words != '0 ? LOAD : DONE) : IDLE)
            : state == LOAD  ? (fire && last ? WRITE : LOAD)
            : state == WRITE ? (word_idx == num - 1'b1 ? FIN : LOAD)
            : state == CHK   ? (fire ? DONE : CHK)
            : IDLE;
    bus.rx_ready = state == LOAD || state == CHK;
    bus.mem_we = state == WRITE;
    busy = state != IDLE;
    done = state == DONE;
  end
  assign bus.mem_data = data_q;
  assign bus.mem_addr = addr_q;
  // Write port is registered on the last byte so it stays stable outside WRITE.
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      word_idx <= '0;
      base <= '0;
      num <= '0;
      data_q <= '0;
      addr_q <= '0;
    end else begin
      state <= state_n;
      if (go) begin
        base <= base_addr;
        num <= num_words;
        word_idx <= '0;
      end
      if (state == LOAD && fire && last) begin
        data_q <= nxt;
        addr_q <= base + word_idx;
      end
      if (state == WRITE) word_idx <= word_idx + 1'b1;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic err_q;
  always_ff @(posedge clk)
    if (rst || go) begin
      csum <= '0;
      err_q <= 1'b0;
    end else if (state == LOAD && fire) csum <= csum ^ bus.rx_data;
    else if (state == CHK && fire && bus.rx_data != csum) err_q <= 1'b1;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader with directed load vectors.
module tb_imem_loader;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  typedef struct {
    bit is_done;
    logic [15:0] addr;
    logic [15:0] data;
    bit after_we;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] num_words = '0;
  logic busy, done, err;
  int n_cmp = 0;
  int n_bad = 0;
  ev_t q[$];
  imem_loader_if #(.DWIDTH(16), .ADDR_WIDTH(16)) bus ();
  imem_loader #(.DWIDTH(16), .ADDR_WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .num_words(num_words),
    .bus(bus),
    .busy(busy),
    .done(done),
    .err(err)
  );
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [15:0] a, input logic [15:0] d);
    q.push_back('{is_done: 1'b0, addr: a, data: d, after_we: 1'b0});
  endtask

  // With checksum support the CHK byte sits between the last write and done.
  task automatic exp_done(input bit after_write);
    q.push_back('{is_done: 1'b1, addr: '0, data: '0, after_we: after_write && !CK});
  endtask

  task automatic pulse_start(input logic [15:0] b, input logic [15:0] n);
    start = 1'b1;
    base_addr = b;
    num_words = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int i;
    repeat (gap) @(negedge clk);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    for (i = 0; i < 100 && !bus.rx_ready; i++) @(negedge clk);
    if (!bus.rx_ready) check("rx_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b[$], input int gap);
    logic [7:0] x = '0;
    foreach (b[i]) begin
      send_byte(b[i], gap);
      x ^= b[i];
    end
    if (CK) send_byte(x, gap);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200 && busy; i++) @(negedge clk);
    check("idle_timeout", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin : monitor
    ev_t e;
    bit prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_we || done) begin
        if (q.size() == 0) check("unexpected_event", {bus.mem_we, done}, 32'd0);
        else begin
          e = q.pop_front();
          check("event_kind", 32'(done), 32'(e.is_done));
          if (bus.mem_we) begin
            check("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
            check("mem_data", 32'(bus.mem_data), 32'(e.data));
          end else check("done_latency", 32'(prev_we), 32'(e.after_we));
        end
      end
      prev_we = bus.mem_we;
    end
  end

  initial begin : stim
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_data", 32'(bus.mem_data), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    // basic two-word load
    exp_wr(16'h0010, 16'h1234);
    exp_wr(16'h0011, 16'h5678);
    exp_done(1'b1);
    pulse_start(16'h0010, 16'd2);
    check("busy_after_start", 32'(busy), 32'd1);
    send_bytes('{8'h34, 8'h12, 8'h78, 8'h56}, 0);
    wait_idle();
    check("hold_data", 32'(bus.mem_data), 32'h5678);
    check("hold_addr", 32'(bus.mem_addr), 32'h0011);
    // zero-length load: done next cycle, never ready
    exp_done(1'b0);
    pulse_start(16'h0040, 16'd0);
    check("n0_busy", 32'(busy), 32'd1);
    check("n0_rx_ready", 32'(bus.rx_ready), 32'd0);
    @(negedge clk);
    check("n0_idle", 32'(busy), 32'd0);
    check("n0_rx_ready2", 32'(bus.rx_ready), 32'd0);
    // address wrap
    exp_wr(16'hFFFF, 16'h0001);
    exp_wr(16'h0000, 16'h0002);
    exp_done(1'b1);
    pulse_start(16'hFFFF, 16'd2);
    send_bytes('{8'h01, 8'h00, 8'h02, 8'h00}, 0);
    wait_idle();
    // gapped stream with a start pulse while busy
    exp_wr(16'h0010, 16'h1234);
    exp_wr(16'h0011, 16'h5678);
    exp_done(1'b1);
    pulse_start(16'h0010, 16'd2);
    send_byte(8'h34, 5);
    pulse_start(16'h0100, 16'd0);
    send_byte(8'h12, 5);
    pulse_start(16'h0200, 16'd7);
    send_byte(8'h78, 5);
    send_byte(8'h56, 5);
    if (CK) send_byte(8'h34 ^ 8'h12 ^ 8'h78 ^ 8'h56, 5);
    wait_idle();
    // reset mid-word aborts; next load starts clean
    pulse_start(16'h0020, 16'd2);
    send_byte(8'hEE, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem_we", 32'(bus.mem_we), 32'd0);
    check("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
    repeat (3) @(negedge clk);
    exp_wr(16'h0030, 16'hABCD);
    exp_done(1'b1);
    pulse_start(16'h0030, 16'd1);
    send_bytes('{8'hCD, 8'hAB}, 0);
    wait_idle();
    check("hold_data2", 32'(bus.mem_data), 32'hABCD);
    check("hold_addr2", 32'(bus.mem_addr), 32'h0030);
    check("err_clean", 32'(err), 32'd0);
    if (CK) begin
      exp_wr(16'h0050, 16'h1234);
      exp_done(1'b0);
      pulse_start(16'h0050, 16'd1);
      send_byte(8'h34, 0);
      send_byte(8'h12, 0);
      send_byte(8'h26, 0);
      wait_idle();
      check("ck_good_err", 32'(err), 32'd0);
      exp_wr(16'h0050, 16'h1234);
      exp_done(1'b0);
      pulse_start(16'h0050, 16'd1);
      send_byte(8'h34, 0);
      send_byte(8'h12, 0);
      send_byte(8'h00, 0);
      wait_idle();
      check("ck_bad_err", 32'(err), 32'd1);
    end
    repeat (3) @(negedge clk);
    check("events_left", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DWIDTH, default 16, memory word width; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 16, memory address width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  one-cycle load request; sampled only in IDLE.
REQ-006 base_addr  in  ADDR_WIDTH  first imem word address; sampled with start.
REQ-007 num_words  in  ADDR_WIDTH  word count; sampled with start.
REQ-008 rx_data  in  8  byte stream payload.
REQ-009 rx_valid  in  1  rx_data valid.
REQ-010 rx_ready  out  1  loader accepts byte; transfer when rx_valid && rx_ready.
REQ-011 mem_data  out  DWIDTH  write data to imem data port.
REQ-012 mem_addr  out  ADDR_WIDTH  write address to imem addr port.
REQ-013 mem_we  out  1  imem write enable; one-cycle pulse per word.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse on load completion.
REQ-016 err  out  1  sticky checksum error; cleared by next accepted start or rst.

Function
REQ-017 States SHALL be IDLE, LOAD, WRITE, CHK, DONE; CHK exists only per REQ-031.
REQ-018 IDLE: rx_ready=0, mem_we=0; start with num_words>0 -> LOAD; start with num_words==0 -> DONE; start outside IDLE SHALL be ignored.
REQ-019 LOAD: rx_ready=1; each transfer shifts a byte in; first byte of a word SHALL be least significant.
REQ-020 On the transfer completing byte DWIDTH/8 of a word -> WRITE next cycle; rx_valid low SHALL stall indefinitely without state change.
REQ-021 WRITE: rx_ready=0, mem_we=1 for exactly one cycle, mem_addr=base_addr+word_idx (modulo 2^ADDR_WIDTH, wrap permitted), mem_data=assembled word.
REQ-022 After WRITE: word_idx increments; if word_idx was num_words-1 -> CHK (macro defined) or DONE; else LOAD.
REQ-023 DONE: done=1 for one cycle, busy=1, then IDLE.
REQ-024 mem_data and mem_addr SHALL hold last written values when mem_we=0.
REQ-025 Latency: last byte transfer to mem_we = 1 cycle; final mem_we to done = 1 cycle (no macro).
REQ-026 num_words = 2^ADDR_WIDTH-1 SHALL be supported; word/byte counters SHALL not overflow.

Reset
REQ-027 rst SHALL force IDLE, word_idx=0, byte counter=0, shift register=0.
REQ-028 Reset values: rx_ready=0, mem_we=0, mem_data=0, mem_addr=0, busy=0, done=0, err=0.
REQ-029 rst asserted mid-load SHALL abort immediately; no further mem_we, no done pulse; rst dominates start.

Configuration
REQ-030 Macro IMEM_LOADER_CHECKSUM_EN selects trailing-checksum support.
REQ-031 Defined: 8-bit XOR of all payload bytes accumulated; after final WRITE enter CHK with rx_ready=1; one checksum byte accepted; mismatch sets err; then DONE. Undefined: no CHK state, err tied 0, no trailing byte consumed.

Structure
REQ-032 State encoding typedef and BYTES_PER_WORD = DWIDTH/8 SHALL live in shared package imem_pkg.
REQ-033 Optional sub-module imem_word_asm (byte shift register + byte counter) SHALL be the only sub-module.

Verification
REQ-034 start, base=0x0010, n=2, bytes 34 12 78 56 -> mem_we pulses addr 0x0010 data 0x1234, addr 0x0011 data 0x5678; done 1 cycle after second pulse.
REQ-035 start with n=0 -> done next cycle, no mem_we, rx_ready never high.
REQ-036 base=0xFFFF, n=2, bytes 01 00 02 00 -> writes 0xFFFF=0x0001, 0x0000=0x0002 (wrap).
REQ-037 rx_valid gapped 5 cycles between bytes, start pulsed while busy -> identical writes, start ignored.
REQ-038 rst mid-word after 1 byte of 2 -> no mem_we, busy=0 next cycle; next load from fresh start correct.
REQ-039 With IMEM_LOADER_CHECKSUM_EN: bytes 34 12 then 26 -> err=0; then 34 12 then 00 -> err=1, done still pulses.
